// File: rtl/multiplier_sequencer_pkg.sv
// rtl/multiplier_sequencer_pkg.sv - shared width and state encoding for the shift-add multiplier sequencer
package multiplier_pkg;

  localparam int MULT_WIDTH = 8;
  localparam int MULT_CNT_W = $clog2(MULT_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ADD,
    SHIFT,
    HOLD
  } mult_state_e;

endpackage

// File: rtl/multiplier_sequencer_if.sv
// rtl/multiplier_sequencer_if.sv - operator inputs, B LSB and datapath control strobes of the sequencer
interface multiplier_sequencer_if;

  logic Run;
  logic ClearA_LoadB;
  logic M;
  logic Clr_XA;
  logic Ld_B;
  logic Ld_XA;
  logic Add;
  logic Sub;
  logic Shift_En;
  logic Done;
  logic Busy;

  modport master (
    output Run, ClearA_LoadB, M,
    input  Clr_XA, Ld_B, Ld_XA, Add, Sub, Shift_En, Done, Busy
  );

  modport slave (
    input  Run, ClearA_LoadB, M,
    output Clr_XA, Ld_B, Ld_XA, Add, Sub, Shift_En, Done, Busy
  );

endinterface

// File: rtl/multiplier_sequencer_step_counter.sv
// rtl/multiplier_sequencer_step_counter.sv - step counter with clear, increment and terminal-count flag
module mult_step_counter
  import multiplier_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/multiplier_sequencer.sv
// rtl/multiplier_sequencer.sv - shift-add multiplier control FSM; MULTIPLIER_SEQUENCER_SKIP_ZERO_EN folds zero-bit steps into one cycle
module multiplier_sequencer
  import multiplier_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  multiplier_sequencer_if.slave bus
);

  mult_state_e state;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        last;

  logic clr_xa, ld_b, ld_xa, add, sub, shift_en, done, busy;

  mult_step_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .last  (last)
  );

  always_comb begin
    cnt_clr = (state == CLR);
    cnt_inc = (state == SHIFT) && !last;
`ifdef MULTIPLIER_SEQUENCER_SKIP_ZERO_EN
    if (state == ADD && !bus.M && !last) begin
      cnt_inc = 1'b1;
    end
`endif
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:  if (bus.Run) state <= CLR;
        CLR:   state <= ADD;
        ADD: begin
`ifdef MULTIPLIER_SEQUENCER_SKIP_ZERO_EN
          // A zero multiplier bit needs no add, so this cycle doubles as the shift.
          if (bus.M)     state <= SHIFT;
          else if (last) state <= HOLD;
          else           state <= ADD;
`else
          state <= SHIFT;
`endif
        end
        SHIFT: state <= last ? HOLD : ADD;
        HOLD:  if (!bus.Run) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are forced low while reset is held so the datapath never sees a stray load.
  always_comb begin
    clr_xa   = 1'b0;
    ld_b     = 1'b0;
    ld_xa    = 1'b0;
    add      = 1'b0;
    sub      = 1'b0;
    shift_en = 1'b0;
    done     = 1'b0;
    busy     = 1'b0;
    if (Reset_n) begin
      case (state)
        IDLE: begin
          if (!bus.Run && bus.ClearA_LoadB) begin
            clr_xa = 1'b1;
            ld_b   = 1'b1;
          end
        end
        CLR: begin
          clr_xa = 1'b1;
          busy   = 1'b1;
        end
        ADD: begin
          busy  = 1'b1;
          ld_xa = bus.M;
          add   = bus.M && !last;
          sub   = bus.M && last;
`ifdef MULTIPLIER_SEQUENCER_SKIP_ZERO_EN
          shift_en = !bus.M;
`endif
        end
        SHIFT: begin
          shift_en = 1'b1;
          busy     = 1'b1;
        end
        HOLD: done = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.Clr_XA   = clr_xa;
  assign bus.Ld_B     = ld_b;
  assign bus.Ld_XA    = ld_xa;
  assign bus.Add      = add;
  assign bus.Sub      = sub;
  assign bus.Shift_En = shift_en;
  assign bus.Done     = done;
  assign bus.Busy     = busy;

endmodule

// File: tb/tb_multiplier_sequencer.sv
// tb/tb_multiplier_sequencer.sv - randomized self-checking bench with schedule and datapath reference model
module tb_multiplier_sequencer;

  logic Clk;
  logic Reset_n;
  multiplier_sequencer_if ifc ();

  multiplier_sequencer dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (ifc)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  localparam logic [7:0] V_IDLE  = 8'b0000_0000;
  localparam logic [7:0] V_LOAD  = 8'b1100_0000;
  localparam logic [7:0] V_CLR   = 8'b1000_0001;
  localparam logic [7:0] V_SHIFT = 8'b0000_0101;
  localparam logic [7:0] V_HOLD  = 8'b0000_0010;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference datapath: 9-bit adder into X:A, arithmetic shift of X-A-B
  logic [7:0] sw = 8'h00;
  logic [7:0] a_reg = 8'h00;
  logic [7:0] b_reg = 8'h00;
  logic       x_reg = 1'b0;
  logic [8:0] operand;
  logic [8:0] sum;

  assign ifc.M   = b_reg[0];
  assign operand = ifc.Add ? {sw[7], sw} : (ifc.Sub ? (~{sw[7], sw} + 9'd1) : 9'd0);
  assign sum     = {a_reg[7], a_reg} + operand;

  always @(posedge Clk) begin
    if (ifc.Clr_XA) begin
      x_reg <= 1'b0;
      a_reg <= 8'h00;
    end else if (ifc.Ld_XA) begin
      x_reg <= sum[8];
      a_reg <= sum[7:0];
    end else if (ifc.Shift_En) begin
      a_reg <= {x_reg, a_reg[7:1]};
    end
    if (ifc.Ld_B)          b_reg <= sw;
    else if (ifc.Shift_En) b_reg <= {a_reg[0], b_reg[7:1]};
  end

  logic [7:0] outv;
  assign outv = {ifc.Clr_XA, ifc.Ld_B, ifc.Ld_XA, ifc.Add, ifc.Sub, ifc.Shift_En, ifc.Done, ifc.Busy};

  logic [7:0] exp_q[$];
  int ncyc = 0;
  int done_cyc = 0;
  bit done_seen = 1'b0;
  int shift_cnt = 0;

  always @(negedge Clk) begin
    ncyc++;
    if (ifc.Done && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = ncyc;
    end
    if (ifc.Shift_En) shift_cnt++;
    if (exp_q.size() > 0) chk("ctl_outputs", {24'd0, outv}, {24'd0, exp_q.pop_front()});
  end

  function automatic void build_steps(input logic [7:0] b, output logic [7:0] q[$]);
    q = {};
    for (int k = 0; k < 8; k++) begin
      logic m;
      m = b[k];
`ifdef MULTIPLIER_SEQUENCER_SKIP_ZERO_EN
      if (!m) begin
        q.push_back(V_SHIFT);
        continue;
      end
`endif
      q.push_back({2'b00, m, m && (k < 7), m && (k == 7), 3'b001});
      q.push_back(V_SHIFT);
    end
  endfunction

  function automatic int exp_done_edge(input logic [7:0] b);
`ifdef MULTIPLIER_SEQUENCER_SKIP_ZERO_EN
    return 9 + $countones(b);
`else
    return 17;
`endif
  endfunction

  task automatic load_and_start(input logic [7:0] b, input logic [7:0] s);
    @(posedge Clk); #1;
    sw = b; ifc.ClearA_LoadB = 1'b1; ifc.Run = 1'b0;
    exp_q.push_back(V_LOAD);
    @(posedge Clk); #1;
    // Run and ClearA_LoadB together: Run wins, no load/clear strobe
    sw = s; ifc.ClearA_LoadB = 1'b1; ifc.Run = 1'b1;
    exp_q.push_back(V_IDLE);
  endtask

  task automatic do_run(input logic [7:0] b, input logic [7:0] s, input int drop_at,
                        input int hold, output int done_e, output int shifts);
    logic [7:0] steps[$];
    logic signed [15:0] prod;
    int t0;
    build_steps(b, steps);
    load_and_start(b, s);
    @(posedge Clk); #1;
    t0 = ncyc + 1; done_seen = 1'b0; shift_cnt = 0;
    ifc.ClearA_LoadB = 1'($urandom_range(0, 1));
    ifc.Run = (drop_at > 0);
    exp_q.push_back(V_CLR);
    for (int j = 0; j < steps.size(); j++) begin
      @(posedge Clk); #1;
      ifc.ClearA_LoadB = 1'($urandom_range(0, 1));
      ifc.Run = (j + 1 < drop_at);
      exp_q.push_back(steps[j]);
    end
    @(posedge Clk); #1;
    ifc.ClearA_LoadB = 1'($urandom_range(0, 1));
    if (ifc.Run) begin
      repeat (hold) begin
        exp_q.push_back(V_HOLD);
        @(posedge Clk); #1;
        ifc.ClearA_LoadB = 1'($urandom_range(0, 1));
      end
    end
    ifc.Run = 1'b0;
    exp_q.push_back(V_HOLD);
    @(posedge Clk); #1;
    ifc.ClearA_LoadB = 1'b0;
    exp_q.push_back(V_IDLE);
    @(negedge Clk); #1;
    prod = $signed(s) * $signed(b);
    chk("product", {16'd0, a_reg, b_reg}, {16'd0, prod});
    chk("done_edge", done_seen ? done_cyc - t0 : -1, exp_done_edge(b));
    chk("shift_pulses", shift_cnt, 8);
    done_e = done_seen ? done_cyc - t0 : -1;
    shifts = shift_cnt;
  endtask

  task automatic reset_mid_add();
    logic [7:0] steps[$];
    build_steps(8'hFF, steps);
    load_and_start(8'hFF, 8'h3C);
    @(posedge Clk); #1;
    ifc.ClearA_LoadB = 1'b0;
    exp_q.push_back(V_CLR);
    for (int j = 0; j < 8; j++) begin
      @(posedge Clk); #1;
      exp_q.push_back(steps[j]);
    end
    @(posedge Clk); #1;
    chk("add_step4_before_reset", {24'd0, outv}, 32'b0011_0001);
    ifc.ClearA_LoadB = 1'b1;
    Reset_n = 1'b0;
    #1;
    chk("outputs_in_reset", {24'd0, outv}, 32'd0);
    @(posedge Clk); #1;
    ifc.Run = 1'b0; ifc.ClearA_LoadB = 1'b0; Reset_n = 1'b1;
    @(negedge Clk);
    chk("idle_after_reset", {24'd0, outv}, 32'd0);
  endtask

  initial begin
    int de, sc;
    logic [7:0] rb, rs;
    Reset_n = 1'b0;
    ifc.Run = 1'b0;
    ifc.ClearA_LoadB = 1'b1;
    repeat (2) @(negedge Clk);
    chk("reset_state", {24'd0, outv}, 32'd0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    ifc.ClearA_LoadB = 1'b0;

    do_run(8'h00, 8'($urandom), 99, 3, de, sc);
    do_run(8'h81, 8'h07, 99, 1, de, sc);
    chk("pin_fc87", {16'd0, a_reg, b_reg}, 32'h0000_FC87);
`ifdef MULTIPLIER_SEQUENCER_SKIP_ZERO_EN
    chk("pin_done_81", de, 11);
`else
    chk("pin_done_81", de, 17);
`endif
    do_run(8'hC3, 8'($urandom), 7, 0, de, sc);
    reset_mid_add();
    do_run(8'h05, 8'h33, 99, 2, de, sc);
    chk("pin_shifts_05", sc, 8);
`ifdef MULTIPLIER_SEQUENCER_SKIP_ZERO_EN
    chk("pin_done_05", de, 11);
`else
    chk("pin_done_05", de, 17);
`endif
    for (int r = 0; r < 10; r++) begin
      rb = 8'($urandom);
      rs = 8'($urandom);
      do_run(rb, rs, int'($urandom_range(0, 20)), int'($urandom_range(0, 3)), de, sc);
    end
    repeat (2) @(negedge Clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multiplier_sequencer.md
# multiplier_sequencer

Control unit for the 8-bit shift-add multiplier. It sequences the nine-bit adder/subtractor (Add/Sub select), the X/A accumulator load and clear, and the combined X-A-B right shift. For each multiplier bit it runs one add (or subtract) step and one shift step. It then holds the result with Done asserted until the operator releases Run.

## Interface
- WIDTH, 8, number of multiplier bits, which is also the number of add/shift steps
- Clk  in  1  system clock; all state changes on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Run  in  1  start request, level-sensitive, already synchronized upstream
- ClearA_LoadB  in  1  operator request, valid only in IDLE: clear X/A and load B from switches
- M  in  1  current LSB of the B register
- Clr_XA  out  1  clear the X and A registers
- Ld_B  out  1  load B from switches
- Ld_XA  out  1  capture the adder result into X and A
- Add  out  1  adder operand select: switches
- Sub  out  1  adder operand select: two's complement of switches
- Shift_En  out  1  arithmetic right shift of X-A-B by one
- Done  out  1  product valid in X-A-B
- Busy  out  1  sequence in progress

## Operation
- States: IDLE, CLR, ADD, SHIFT, HOLD. Step counter `cnt` is $clog2(WIDTH) bits.
- **IDLE**
  - If Run=1: go to CLR.
  - Else if ClearA_LoadB=1: Clr_XA=1 and Ld_B=1 (combinational).
  - Run has priority. When both are high, Ld_B and Clr_XA are suppressed that cycle.
- **CLR**
  - Clr_XA=1, cnt<=0, go to ADD.
- **ADD** (Mealy on M)
  - Ld_XA=M.
  - Add=M when cnt<WIDTH-1.
  - Sub=M when cnt==WIDTH-1.
  - Go to SHIFT.
- **SHIFT**
  - Shift_En=1.
  - If cnt==WIDTH-1: go to HOLD.
  - Else: cnt<=cnt+1, go to ADD.
- **HOLD**
  - Done=1.
  - Stay while Run=1. Go to IDLE when Run=0.
- Add and Sub are never both 1. With both 0, the adder's B operand is zero.
- Busy=1 in CLR, ADD and SHIFT.
- Outputs not listed for a state are 0.
- Run deasserted during CLR, ADD or SHIFT is ignored; the sequence completes.
- ClearA_LoadB outside IDLE is ignored.
- Reset_n low at any time: state goes to IDLE and cnt to 0 immediately. All outputs are 0 while Reset_n=0.

## Timing
- Edge 0 is the first rising edge that samples Run=1 in IDLE.
- CLR is occupied after edge 0.
- Step k (0..WIDTH-1):
  - ADD is occupied after edge 1+2k.
  - SHIFT is occupied after edge 2+2k.
- Done rises after edge 2·WIDTH+1 (edge 17 for WIDTH=8).
- Control outputs are valid in the cycle they are asserted. Datapath registers capture on the following edge.
- M must be stable by the end of each ADD cycle. It reflects the B LSB after the previous shift.
- Restart requires Run to be 0 for at least one cycle in HOLD, then Run=1 in IDLE.

## Configuration
- Macro: `MULTIPLIER_SEQUENCER_SKIP_ZERO_EN`.
- **Defined:** in ADD with M=0, the add step is skipped and the cycle acts as the shift cycle:
  - Shift_En=1 and Ld_XA=0.
  - If cnt==WIDTH-1: go to HOLD. Else: cnt<=cnt+1 and stay in ADD.
  - Done rises after edge WIDTH+1+popcount(B).
- **Undefined:** the fixed two-cycle-per-step schedule described above applies.

## Structure
- Package `multiplier_pkg`:
  - state enum `mult_state_e` {IDLE, CLR, ADD, SHIFT, HOLD}
  - constant `MULT_WIDTH = 8`
- Sub-module `mult_step_counter`:
  - step counter with clear, increment and terminal-count output `last`
  - asynchronous active-low reset
  - instantiated once

## Test plan
- Reset_n pulsed low while in ADD with cnt=4 → all outputs 0 immediately. After release: IDLE with Done=0, Busy=0.
- ClearA_LoadB=1, Run=0 in IDLE → Clr_XA=1 and Ld_B=1 in the same cycle. ClearA_LoadB=1 during SHIFT → no Ld_B.
- B=0x00, Run held high (skip macro off):
  - Clr_XA after edge 0
  - 8 ADD cycles with Ld_XA=Add=Sub=0
  - 8 Shift_En pulses
  - Done after edge 17, held while Run=1
- B=0x81:
  - Add=1 and Ld_XA=1 only in step 0
  - Sub=1 and Ld_XA=1 only in step 7
  - Add and Sub never both 1
  - product of switches=0x07 and B=0x81 checked as 0xFC87 in A:B
- Run dropped at step 3 → sequence completes, Done after edge 17.
  - Then Run=0 in HOLD → IDLE next edge.
  - Then Run=1 → new CLR.
- With `MULTIPLIER_SEQUENCER_SKIP_ZERO_EN` and B=0x05 → exactly 8 Shift_En pulses, Done after edge 11.
